// File: rtl/retro_bram_arbiter.sv
// Two-port arbiter onto a single BRAM port; round-robin by default, port-0 priority with
// starvation limit when RETRO_BRAM_ARB_PRIORITY_EN is defined. Grant is same-cycle (0 latency),
// read data returns 1 cycle after grant. Backpressure: a requester holds its request until ReqReady.
module retro_bram_arbiter #(
    parameter int AddressBusWidth = 12,
    parameter int DataBusWidth    = 1,
    parameter int MaxWait         = 4
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [1:0]                   ReqAccess,
    input  logic [2*DataBusWidth-1:0]    ReqWrite,
    input  logic [2*AddressBusWidth-1:0] ReqAddress,
    input  logic [16*DataBusWidth-1:0]   ReqDToTarget,
    output logic [1:0]                   ReqReady,
    output logic [1:0]                   ReqDataReady,
    output logic [8*DataBusWidth-1:0]    ReqDToInitiator,
    output logic                         MemAccess,
    output logic [DataBusWidth-1:0]      MemWrite,
    output logic [AddressBusWidth-1:0]   MemAddress,
    output logic [8*DataBusWidth-1:0]    MemDToTarget,
    input  logic [8*DataBusWidth-1:0]    MemDToInitiator
);

    localparam int DW = DataBusWidth;
    localparam int AW = AddressBusWidth;
    localparam int BW = 8 * DataBusWidth;

    logic [1:0] grant;
    logic       pick_port1;
    logic       sel;
    logic       rd_valid;
    logic       rd_id;

`ifdef RETRO_BRAM_ARB_PRIORITY_EN
    localparam logic [3:0] MaxWaitCnt = 4'(MaxWait);

    logic [3:0] starve_cnt;

    // Port 1 only wins contention once it has been denied MaxWait cycles in a row.
    assign pick_port1 = (starve_cnt == MaxWaitCnt);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            starve_cnt <= 4'd0;
        end else if (ReqAccess[1] && !grant[1]) begin
            starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= 4'd0;
        end
    end
`else
    logic last;
    logic cfg_unused;

    assign cfg_unused = (MaxWait > 15);
    assign pick_port1 = (last == 1'b0);

    // Reset value 1 lets port 0 win the first contention.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            last <= 1'b1;
        end else if (|grant) begin
            last <= grant[1];
        end
    end
`endif

    always_comb begin
        grant = 2'b00;
        if (Reset_n) begin
            unique case (ReqAccess)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = pick_port1 ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel          = grant[1];
    assign ReqReady     = grant;
    assign MemAccess    = |grant;
    assign MemWrite     = MemAccess ? (sel ? ReqWrite[DW +: DW] : ReqWrite[0 +: DW]) : '0;
    assign MemAddress   = sel ? ReqAddress[AW +: AW] : ReqAddress[0 +: AW];
    assign MemDToTarget = sel ? ReqDToTarget[BW +: BW] : ReqDToTarget[0 +: BW];

    // Read data is shared; only the DataReady strobe identifies the owner.
    assign ReqDToInitiator = MemDToInitiator;
    assign ReqDataReady    = (Reset_n && rd_valid) ? (rd_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rd_valid <= 1'b0;
            rd_id    <= 1'b0;
        end else begin
            rd_valid <= MemAccess && (MemWrite == '0);
            rd_id    <= sel;
        end
    end

endmodule

// File: tb/tb_retro_bram_arbiter.sv
// Directed bench for retro_bram_arbiter with a registered-read BRAM model.
module tb_retro_bram_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic [1:0]  ReqAccess;
    logic [1:0]  ReqWrite;
    logic [23:0] ReqAddress;
    logic [15:0] ReqDToTarget;
    logic [1:0]  ReqReady;
    logic [1:0]  ReqDataReady;
    logic [7:0]  ReqDToInitiator;
    logic        MemAccess;
    logic [0:0]  MemWrite;
    logic [11:0] MemAddress;
    logic [7:0]  MemDToTarget;
    logic [7:0]  MemDToInitiator;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];

    retro_bram_arbiter dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .ReqAccess       (ReqAccess),
        .ReqWrite        (ReqWrite),
        .ReqAddress      (ReqAddress),
        .ReqDToTarget    (ReqDToTarget),
        .ReqReady        (ReqReady),
        .ReqDataReady    (ReqDataReady),
        .ReqDToInitiator (ReqDToInitiator),
        .MemAccess       (MemAccess),
        .MemWrite        (MemWrite),
        .MemAddress      (MemAddress),
        .MemDToTarget    (MemDToTarget),
        .MemDToInitiator (MemDToInitiator)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // BRAM model: preload during reset, byte write, data out one cycle after access.
    always @(posedge Clk) begin
        if (!Reset_n) begin
            mem[12'h010] <= 8'hA5;
            mem[12'h100] <= 8'h11;
            mem[12'h200] <= 8'h22;
        end else if (MemAccess) begin
            if (MemWrite[0]) mem[MemAddress] <= MemDToTarget;
            MemDToInitiator <= mem[MemAddress];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [1:0] exp_g;
    logic [1:0] prev_g;

    initial begin
        Reset_n      = 1'b0;
        ReqAccess    = 2'b11;
        ReqWrite     = 2'b00;
        ReqAddress   = {12'h200, 12'h100};
        ReqDToTarget = 16'h0000;
        step();
        step();

        // Outputs gated while in reset even with both ports requesting.
        chk("rst_ready",   ReqReady, 2'b00);
        chk("rst_access",  MemAccess, 1'b0);
        chk("rst_write",   MemWrite, 1'b0);
        chk("rst_dready",  ReqDataReady, 2'b00);

        // Single read by port 0, granted in the first cycle after release.
        Reset_n    = 1'b1;
        ReqAccess  = 2'b01;
        ReqAddress = {12'h000, 12'h010};
        #1;
        chk("rd0_ready",  ReqReady, 2'b01);
        chk("rd0_access", MemAccess, 1'b1);
        chk("rd0_addr",   MemAddress, 12'h010);
        chk("rd0_write",  MemWrite, 1'b0);
        step();
        ReqAccess = 2'b00;
        #1;
        chk("rd0_dready", ReqDataReady, 2'b01);
        chk("rd0_data",   ReqDToInitiator, 8'hA5);
        step();
        chk("rd0_dready_once", ReqDataReady, 2'b00);
        chk("idle_write",      MemWrite, 1'b0);

        // Port 1 writes 0x3C to 0x020, then port 0 reads it back.
        ReqAccess    = 2'b10;
        ReqWrite     = 2'b10;
        ReqAddress   = {12'h020, 12'h000};
        ReqDToTarget = 16'h3C00;
        #1;
        chk("wr1_ready", ReqReady, 2'b10);
        chk("wr1_write", MemWrite, 1'b1);
        chk("wr1_addr",  MemAddress, 12'h020);
        chk("wr1_data",  MemDToTarget, 8'h3C);
        step();
        ReqAccess    = 2'b01;
        ReqWrite     = 2'b00;
        ReqAddress   = {12'h000, 12'h020};
        ReqDToTarget = 16'h0000;
        #1;
        chk("wr1_no_dready", ReqDataReady, 2'b00);
        chk("rd020_ready",   ReqReady, 2'b01);
        step();
        ReqAccess = 2'b00;
        #1;
        chk("rd020_dready", ReqDataReady, 2'b01);
        chk("rd020_data",   ReqDToInitiator, 8'h3C);
        step();

        // Continuous contention from reset.
        Reset_n    = 1'b0;
        ReqAccess  = 2'b11;
        ReqAddress = {12'h200, 12'h100};
        step();
        Reset_n = 1'b1;
        prev_g  = 2'b00;
        for (int k = 0; k < 12; k++) begin
`ifdef RETRO_BRAM_ARB_PRIORITY_EN
            exp_g = (k % 5 == 4) ? 2'b10 : 2'b01;
`else
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            #1;
            chk($sformatf("cont_grant_%0d", k), ReqReady, exp_g);
            chk($sformatf("cont_dready_%0d", k), ReqDataReady, prev_g);
            if (prev_g != 2'b00)
                chk($sformatf("cont_data_%0d", k), ReqDToInitiator,
                    (prev_g == 2'b01) ? 8'h11 : 8'h22);
            prev_g = exp_g;
            step();
        end

        // Read granted, then reset asserted the following cycle.
        ReqAccess  = 2'b01;
        ReqAddress = {12'h000, 12'h010};
        Reset_n    = 1'b0;
        step();
        Reset_n = 1'b1;
        #1;
        chk("mid_grant", ReqReady, 2'b01);
        step();
        Reset_n   = 1'b0;
        ReqAccess = 2'b00;
        #1;
        chk("mid_dready_inrst", ReqDataReady, 2'b00);
        step();
        Reset_n   = 1'b1;
        ReqAccess = 2'b11;
        ReqAddress = {12'h200, 12'h100};
        #1;
        chk("mid_dready_after", ReqDataReady, 2'b00);
        chk("mid_first_contention", ReqReady, 2'b01);
        step();
        ReqAccess = 2'b00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/retro_bram_arbiter.md
RETRO_BRAM_ARBITER -- requirements
Module: retro_bram_arbiter

Interface
REQ-001 The block SHALL provide parameter AddressBusWidth, default 12, meaning the BRAM word-address width.
REQ-002 The block SHALL provide parameter DataBusWidth, default 1, meaning the data width in bytes, with one write-enable bit per byte.
REQ-003 The block SHALL provide parameter MaxWait, default 4, range 1-15, meaning the starvation limit in cycles (used only when RETRO_BRAM_ARB_PRIORITY_EN is defined).
REQ-004 The block SHALL have one clock, Clk, and its reset SHALL be synchronous and active-low, named Reset_n.
REQ-005 Ports SHALL be:
- Clk  in  1  clock
- Reset_n  in  1  synchronous active-low reset
- ReqAccess  in  2  per-requester access request
- ReqWrite  in  2 x DataBusWidth  per-requester byte write mask (all zero = read)
- ReqAddress  in  2 x AddressBusWidth  per-requester address
- ReqDToTarget  in  2 x 8*DataBusWidth  per-requester write data
- ReqReady  out  2  grant; the transfer occurs on the edge where ReqAccess and ReqReady are both 1
- ReqDataReady  out  2  read data valid, one cycle
- ReqDToInitiator  out  8*DataBusWidth  read data, shared by both requesters
- MemAccess  out  1  BRAM access
- MemWrite  out  DataBusWidth  BRAM byte write mask
- MemAddress  out  AddressBusWidth  BRAM address
- MemDToTarget  out  8*DataBusWidth  BRAM write data
- MemDToInitiator  in  8*DataBusWidth  BRAM read data, valid the cycle after MemAccess

Function
REQ-006 Each requester SHALL hold its Access, Write, Address and data stable until it samples ReqReady high.
REQ-007 Grant SHALL be combinational from the current requests and registered state; at most one ReqReady bit SHALL be high per cycle.
REQ-008 A single requesting port SHALL be granted in the same cycle, so throughput SHALL be one transfer per cycle with no idle cycles between grants.
REQ-009 MemAccess SHALL equal the OR of the ReqReady bits, and MemWrite, MemAddress and MemDToTarget SHALL be muxed from the granted port.
REQ-010 When no port is granted, MemWrite SHALL be 0; MemAddress and MemDToTarget are don't-care.
REQ-011 Round-robin mode: when both ports request, the port not equal to register Last SHALL be granted.
REQ-012 Last SHALL update to the granted port on every grant and SHALL hold when no port is granted.
REQ-013 Read return: on a granted read (ReqWrite of the granted port all zero), the block SHALL register RdValid=1 and RdId=granted port.
REQ-014 In the next cycle, ReqDataReady[RdId] SHALL be 1 for exactly one cycle, and ReqDToInitiator SHALL equal MemDToInitiator.
REQ-015 A granted write SHALL NOT produce ReqDataReady, including for partial byte masks.
REQ-016 Back-to-back reads from alternating ports SHALL return data in issue order, each exactly one cycle after its own grant.
REQ-017 Every output except the data buses SHALL be combinational from registered state and current inputs only; there SHALL be no combinational path from MemDToInitiator to any control output.

Reset
REQ-018 While Reset_n=0 at an edge, the block SHALL set Last=1 (port 0 wins the first contention), RdValid=0 and StarveCnt=0.
REQ-019 While Reset_n is low, ReqReady, MemAccess, MemWrite and ReqDataReady SHALL all be 0.
REQ-020 A read granted in the cycle before reset asserts SHALL produce no ReqDataReady.
REQ-021 The first cycle after reset release SHALL be able to grant.

Configuration
REQ-022 Macro RETRO_BRAM_ARB_PRIORITY_EN SHALL select the arbitration policy.
REQ-023 With RETRO_BRAM_ARB_PRIORITY_EN defined, port 0 SHALL win contention, subject to the 4-bit starvation counter StarveCnt.
- StarveCnt SHALL increment each cycle port 1 requests and is denied.
- StarveCnt SHALL clear when port 1 is granted or is not requesting.
- When StarveCnt==MaxWait, port 1 SHALL be granted.
REQ-024 With RETRO_BRAM_ARB_PRIORITY_EN undefined, REQ-011/REQ-012 round-robin SHALL apply and StarveCnt SHALL not exist.

Verification
REQ-025 Single read: port 0 reads address 0x010 holding 0xA5 -> ReqReady[0]=1 in cycle 0; ReqDataReady[0]=1 and data=0xA5 in cycle 1; port 1 sees no DataReady.
REQ-026 Contention, round-robin: both ports request reads continuously from reset -> grants are 0,1,0,1..., and each DataReady goes to the matching port one cycle later.
REQ-027 Write then read: port 1 writes 0x3C to 0x020 with mask 1, then port 0 reads 0x020 -> no DataReady for the write; port 0 receives 0x3C.
REQ-028 Priority mode with MaxWait=4, both ports requesting continuously -> port 0 is granted 4 cycles, then port 1 is granted 1 cycle, repeating.
REQ-029 Reset mid-operation: port 0 read is granted, Reset_n is 0 on the next edge -> ReqDataReady stays 0; after release, port 0 wins first contention.
